// File: rtl/pwm_led_bank_if.sv
// pwm_led_bank_if: active-low button inputs plus LED and channel-select outputs of the
// PWM LED bank. The master side drives the buttons; the slave side is the controller.
interface pwm_led_bank_if #(
  parameter int unsigned LED_COUNT = 6
);
  localparam int unsigned SelW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

  logic                 up;
  logic                 down;
  logic                 sel;
  logic [LED_COUNT-1:0] led;
  logic [SelW-1:0]      sel_idx;

  modport master (
    output up,
    output down,
    output sel,
    input  led,
    input  sel_idx
  );

  modport slave (
    input  up,
    input  down,
    input  sel,
    output led,
    output sel_idx
  );
endinterface

// File: rtl/pwm_led_bank.sv
// pwm_led_bank: per-channel PWM brightness controller driven by three active-low buttons.
// Build option PWM_LED_WRAP_EN makes duty wrap at 0/P instead of saturating.
module pwm_led_bank #(
  parameter int unsigned LED_COUNT = 6,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned COOLDOWN  = 21
) (
  input logic           clk,
  input logic           rst,
  pwm_led_bank_if.slave bus
);

  localparam int unsigned SelW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [PWM_BITS-1:0] PwmMax  = PWM_BITS'((1 << PWM_BITS) - 1);
  localparam logic [PWM_BITS-1:0] PwmLast = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [COOLDOWN-1:0] CoolMax = '1;
  localparam logic [SelW-1:0]     SelLast = SelW'(LED_COUNT - 1);
  localparam logic [PWM_BITS:0]   DutyOne = {{PWM_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ActNone,
    ActSel,
    ActInc,
    ActDec
  } action_e;

  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [COOLDOWN-1:0]  cooldown_q, cooldown_d;
  logic [SelW-1:0]      sel_idx_q, sel_idx_d;
  logic [PWM_BITS-1:0]  duty_q [LED_COUNT];
  logic [PWM_BITS-1:0]  duty_d [LED_COUNT];
  logic [LED_COUNT-1:0] led_q, led_d;

  action_e             action;
  logic [PWM_BITS-1:0] duty_cur;
  logic [PWM_BITS-1:0] duty_up;
  logic [PWM_BITS-1:0] duty_dn;
  logic [PWM_BITS-1:0] duty_new;
  logic [PWM_BITS:0]   duty_inc;
  logic [PWM_BITS:0]   duty_dec;

  // Buttons only count while the rate limiter is idle; up+down together is a no-op.
  always_comb begin
    action = ActNone;
    if (cooldown_q == '0) begin
      if (!bus.sel) begin
        action = ActSel;
      end else if (!bus.up && bus.down) begin
        action = ActInc;
      end else if (!bus.down && bus.up) begin
        action = ActDec;
      end
    end
  end

  always_comb begin
    duty_cur = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (sel_idx_q == SelW'(i)) begin
        duty_cur = duty_q[i];
      end
    end
  end

  // One extra bit exposes the carry/borrow used for saturation or dropped for wrap.
  assign duty_inc = {1'b0, duty_cur} + DutyOne;
  assign duty_dec = {1'b0, duty_cur} - DutyOne;

`ifdef PWM_LED_WRAP_EN
  logic unused_carry;
  assign duty_up      = duty_inc[PWM_BITS-1:0];
  assign duty_dn      = duty_dec[PWM_BITS-1:0];
  assign unused_carry = duty_inc[PWM_BITS] ^ duty_dec[PWM_BITS];
`else
  assign duty_up = duty_inc[PWM_BITS] ? PwmMax : duty_inc[PWM_BITS-1:0];
  assign duty_dn = duty_dec[PWM_BITS] ? '0 : duty_dec[PWM_BITS-1:0];
`endif

  always_comb begin
    pwm_cnt_d  = (pwm_cnt_q == PwmLast) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    cooldown_d = cooldown_q;
    sel_idx_d  = sel_idx_q;
    duty_new   = duty_cur;

    // Saturated inc/dec still loads the cooldown so a held button is not rechecked.
    unique case (action)
      ActSel: begin
        sel_idx_d  = (sel_idx_q == SelLast) ? '0 : sel_idx_q + SelW'(1);
        cooldown_d = CoolMax;
      end
      ActInc: begin
        duty_new   = duty_up;
        cooldown_d = CoolMax;
      end
      ActDec: begin
        duty_new   = duty_dn;
        cooldown_d = CoolMax;
      end
      default: begin
        if (cooldown_q != '0) begin
          cooldown_d = cooldown_q - COOLDOWN'(1);
        end
      end
    endcase

    for (int i = 0; i < LED_COUNT; i++) begin
      duty_d[i] = duty_q[i];
      if (sel_idx_q == SelW'(i)) begin
        duty_d[i] = duty_new;
      end
      led_d[i] = (duty_q[i] > pwm_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      cooldown_q <= '0;
      sel_idx_q  <= '0;
      led_q      <= '0;
      for (int i = 0; i < LED_COUNT; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      cooldown_q <= cooldown_d;
      sel_idx_q  <= sel_idx_d;
      led_q      <= led_d;
      for (int i = 0; i < LED_COUNT; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign bus.led     = led_q;
  assign bus.sel_idx = sel_idx_q;

endmodule

// File: tb/tb_pwm_led_bank.sv
// tb_pwm_led_bank: directed and randomized checks of pwm_led_bank against a cycle-level
// model built from duty ratios, acceptance times and channel indices.
module tb_pwm_led_bank;

  localparam int unsigned LedCount = 3;
  localparam int unsigned PwmBits  = 2;
  localparam int unsigned Cooldown = 3;
  localparam int unsigned SelW     = 2;
  localparam int          P        = (1 << PwmBits) - 1;
  localparam int          Cd       = 1 << Cooldown;

  logic clk = 1'b0;
  logic rst;

  pwm_led_bank_if #(.LED_COUNT(LedCount)) bus ();

  pwm_led_bank #(
    .LED_COUNT(LedCount),
    .PWM_BITS (PwmBits),
    .COOLDOWN (Cooldown)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: duty per channel, selected channel, edges since reset, first edge that may accept.
  int m_duty [LedCount];
  int m_sel;
  int m_k;
  int m_next_ok;

  // Drive buttons (active-low levels) for one edge; return the expected outputs after it.
  task automatic step(input logic u, input logic d, input logic s,
                      output logic [LedCount-1:0] e_led, output int e_sel);
    int v;
    bus.up   = u;
    bus.down = d;
    bus.sel  = s;
    @(posedge clk);
    e_led = '0;
    if (rst) begin
      for (int i = 0; i < LedCount; i++) m_duty[i] = 0;
      m_sel     = 0;
      m_k       = 0;
      m_next_ok = 1;
    end else begin
      m_k++;
      for (int i = 0; i < LedCount; i++) e_led[i] = (m_duty[i] > ((m_k - 1) % P));
      if (m_k >= m_next_ok) begin
        if (!s) begin
          m_sel     = (m_sel + 1) % LedCount;
          m_next_ok = m_k + Cd;
        end else if (u != d) begin
          v = m_duty[m_sel] + (!u ? 1 : -1);
`ifdef PWM_LED_WRAP_EN
          m_duty[m_sel] = (v + P + 1) % (P + 1);
`else
          m_duty[m_sel] = (v > P) ? P : ((v < 0) ? 0 : v);
`endif
          m_next_ok = m_k + Cd;
        end
      end
    end
    e_sel = m_sel;
    #1;
  endtask

  // Idle for P edges and count how many cycles each LED was high.
  task automatic measure(output int hi [LedCount]);
    logic [LedCount-1:0] el;
    int es;
    for (int i = 0; i < LedCount; i++) hi[i] = 0;
    for (int c = 0; c < P; c++) begin
      step(1'b1, 1'b1, 1'b1, el, es);
      for (int i = 0; i < LedCount; i++) hi[i] += int'(bus.led[i]);
    end
  endtask

  task automatic test_reset();
    logic [LedCount-1:0] el;
    int es;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, 1'b0, el, es);
      checks++;
      if (bus.led !== 3'b000 || bus.sel_idx !== 2'd0) begin
        failures++;
        $display("FAIL reset led=%b sel=%0d required led=000 sel=0", bus.led, bus.sel_idx);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b1, 1'b1, el, es);
      checks++;
      if (bus.led !== el || bus.sel_idx !== SelW'(es)) begin
        failures++;
        $display("FAIL reset_idle led=%b sel=%0d required led=%b sel=%0d",
                 bus.led, bus.sel_idx, el, es);
      end
    end
  endtask

  task automatic test_duty_ramp();
    logic [LedCount-1:0] el;
    int es;
    int hi [LedCount];
    for (int n = 1; n <= 3; n++) begin
      step(1'b0, 1'b1, 1'b1, el, es);
      for (int c = 0; c < 9; c++) begin
        step(1'b1, 1'b1, 1'b1, el, es);
        checks++;
        if (bus.led !== el || bus.sel_idx !== SelW'(es)) begin
          failures++;
          $display("FAIL ramp_cycle led=%b sel=%0d required led=%b sel=%0d",
                   bus.led, bus.sel_idx, el, es);
        end
      end
      measure(hi);
      checks++;
      if (hi[0] != n || hi[1] != 0 || hi[2] != 0) begin
        failures++;
        $display("FAIL ramp_duty step=%0d high=%0d/%0d/%0d required %0d/0/0",
                 n, hi[0], hi[1], hi[2], n);
      end
    end
  endtask

  task automatic test_saturation();
    logic [LedCount-1:0] el;
    int es;
    int hi [LedCount];
    int exp_d0;
`ifdef PWM_LED_WRAP_EN
    exp_d0 = 0;
`else
    exp_d0 = 3;
`endif
    step(1'b0, 1'b1, 1'b1, el, es);
    // A down press one cycle later must fall inside the cooldown and be ignored.
    step(1'b1, 1'b0, 1'b1, el, es);
    for (int c = 0; c < 9; c++) begin
      step(1'b1, 1'b1, 1'b1, el, es);
      checks++;
      if (bus.led !== el) begin
        failures++;
        $display("FAIL sat_cycle led=%b required %b", bus.led, el);
      end
    end
    measure(hi);
    checks++;
    if (hi[0] != exp_d0) begin
      failures++;
      $display("FAIL sat_duty high=%0d required %0d", hi[0], exp_d0);
    end
  endtask

  task automatic test_channel_select();
    logic [LedCount-1:0] el;
    int es;
    int hi [LedCount];
    int d0;
`ifdef PWM_LED_WRAP_EN
    d0 = 0;
`else
    d0 = 3;
`endif
    step(1'b1, 1'b1, 1'b0, el, es);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b1, el, es);
    step(1'b0, 1'b1, 1'b1, el, es);
    for (int c = 0; c < 9; c++) step(1'b1, 1'b1, 1'b1, el, es);
    measure(hi);
    checks++;
    if (bus.sel_idx !== 2'd1 || hi[1] != 1 || hi[0] != d0 || hi[2] != 0) begin
      failures++;
      $display("FAIL select sel=%0d high=%0d/%0d/%0d required sel=1 high=%0d/1/0",
               bus.sel_idx, hi[0], hi[1], hi[2], d0);
    end
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b1, 1'b0, el, es);
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 1'b1, 1'b1, el, es);
        checks++;
        if (bus.led !== el || bus.sel_idx !== SelW'(es)) begin
          failures++;
          $display("FAIL select_cycle led=%b sel=%0d required led=%b sel=%0d",
                   bus.led, bus.sel_idx, el, es);
        end
      end
    end
    checks++;
    if (bus.sel_idx !== 2'd0) begin
      failures++;
      $display("FAIL select_wrap sel=%0d required 0", bus.sel_idx);
    end
  endtask

  task automatic test_cooldown_hold();
    logic [LedCount-1:0] el;
    int es;
    int hi [LedCount];
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, el, es);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, 1'b1, el, es);
      checks++;
      if (bus.led !== el) begin
        failures++;
        $display("FAIL hold_cycle c=%0d led=%b required %b", c, bus.led, el);
      end
    end
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b1, el, es);
    measure(hi);
    checks++;
    if (hi[0] != 3) begin
      failures++;
      $display("FAIL hold_count high=%0d required 3", hi[0]);
    end
  endtask

  task automatic test_conflict();
    logic [LedCount-1:0] el;
    int es;
    int hi [LedCount];
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, el, es);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b1, el, es);
    // Cooldown must still be idle, so this press lands immediately.
    step(1'b0, 1'b1, 1'b1, el, es);
    step(1'b1, 1'b0, 1'b1, el, es);
    for (int c = 0; c < 9; c++) begin
      step(1'b1, 1'b1, 1'b1, el, es);
      checks++;
      if (bus.led !== el) begin
        failures++;
        $display("FAIL conflict_cycle led=%b required %b", bus.led, el);
      end
    end
    measure(hi);
    checks++;
    if (hi[0] != 1) begin
      failures++;
      $display("FAIL conflict_duty high=%0d required 1", hi[0]);
    end
  endtask

  task automatic test_reset_mid_cooldown();
    logic [LedCount-1:0] el;
    int es;
    int hi [LedCount];
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, el, es);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, el, es);
    step(1'b1, 1'b1, 1'b1, el, es);
    step(1'b1, 1'b1, 1'b1, el, es);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, el, es);
    checks++;
    if (bus.led !== 3'b000 || bus.sel_idx !== 2'd0) begin
      failures++;
      $display("FAIL midreset_clear led=%b sel=%0d required led=000 sel=0",
               bus.led, bus.sel_idx);
    end
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, el, es);
    for (int c = 0; c < 9; c++) step(1'b1, 1'b1, 1'b1, el, es);
    measure(hi);
    checks++;
    if (hi[0] != 1) begin
      failures++;
      $display("FAIL midreset_press high=%0d required 1", hi[0]);
    end
  endtask

  task automatic test_random();
    logic [LedCount-1:0] el;
    int es;
    logic u, d, s;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      u   = ($urandom_range(2) != 0);
      d   = ($urandom_range(2) != 0);
      s   = ($urandom_range(4) != 0);
      step(u, d, s, el, es);
      checks++;
      if (bus.led !== el || bus.sel_idx !== SelW'(es)) begin
        failures++;
        $display("FAIL random c=%0d led=%b sel=%0d required led=%b sel=%0d",
                 c, bus.led, bus.sel_idx, el, es);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus.up   = 1'b1;
    bus.down = 1'b1;
    bus.sel  = 1'b1;
    for (int i = 0; i < LedCount; i++) m_duty[i] = 0;
    m_sel     = 0;
    m_k       = 0;
    m_next_ok = 1;

    test_reset();
    test_duty_ramp();
    test_saturation();
    test_channel_select();
    test_cooldown_hold();
    test_conflict();
    test_reset_mid_cooldown();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_led_bank.md
# pwm_led_bank

Multi-channel PWM brightness controller for the board LED bar, successor to the single-bar PWM driver. Each of `LED_COUNT` channels has its own duty register. Three active-low push buttons control it: one selects a channel, the other two raise or lower that channel's brightness. A shared rate limiter keeps buttons from repeating too fast. The block sits directly between the board buttons and the LED pins.

## Interface
- `LED_COUNT`, 6: number of LED channels, 1..16.
- `PWM_BITS`, 4: duty resolution. Duty range is 0..P, where P = 2^PWM_BITS-1.
- `COOLDOWN`, 21: width of the button rate-limit counter. Use 3 for simulation and 21 on hardware.
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `up` input, 1 bit: active-low. Increments the selected channel's duty.
- `down` input, 1 bit: active-low. Decrements the selected channel's duty.
- `sel` input, 1 bit: active-low. Advances the selected channel index.
- `led` output, LED_COUNT bits: registered PWM outputs, one per channel.
- `sel_idx` output, max(1,$clog2(LED_COUNT)) bits: index of the currently selected channel.

## Operation
- **PWM counter.** One counter, `pwm_cnt`, is shared by all channels.
  - It counts 0..P-1 and then returns to 0, so the period is P cycles.
  - `led[i]` is registered as `duty[i] > pwm_cnt`.
  - Duty 0 means always off. Duty P means always on. Duty D is high for D of every P cycles.
- **Rate limiter.** A `cooldown` register, COOLDOWN bits wide, gates every button.
  - A button is accepted only on a cycle where `cooldown == 0`.
  - An accepted action loads `cooldown` with 2^COOLDOWN-1.
  - On any cycle where `cooldown != 0`, it decrements by 1 and all buttons are ignored.
- **Button priority** when `cooldown == 0`, in this order:
  - `sel` low: `sel_idx` goes to `sel_idx+1`, wrapping from LED_COUNT-1 to 0. No duty changes.
  - Else, `up` low and `down` high: `duty[sel_idx]` goes to `min(duty+1, P)`.
  - Else, `down` low and `up` high: `duty[sel_idx]` goes to `max(duty-1, 0)`.
  - Else, `up` and `down` both low: no change, and `cooldown` is not loaded.
  - Else, nothing is pressed: idle.
- **Saturation.** Increment at P and decrement at 0 are not actions.
  - Duty holds its value.
  - `cooldown` is still loaded, so a held button does not re-check every cycle.
- **Duty arithmetic.**
  - Widths are PWM_BITS wide, computed one bit wider, so there is no overflow.
  - Only the selected channel's duty is written in a given cycle. All other channels hold.

## Timing
- **Reset values.** A cycle sampled with `rst` high sets all of the following on that edge:
  - `pwm_cnt` = 0
  - `cooldown` = 0
  - `sel_idx` = 0
  - all `duty` = 0
  - `led` = 0
- **Reset priority.** `rst` overrides all other inputs.
- **Reset mid-operation.** Asserting `rst` mid-period or mid-cooldown clears everything on the next edge. The first button press after reset release is accepted immediately.
- **Button latency.** A button sampled low at edge N (with `cooldown` at 0) updates `duty`/`sel_idx` at edge N.
- **LED latency.** `led` reflects the new duty from edge N+1 onward, comparing against the `pwm_cnt` value current at that edge.
- **Repeat rate.** The minimum spacing between two accepted actions is 2^COOLDOWN cycles.
- **Input synchronisation.** Buttons are sampled raw. Synchronisation is the top-level's responsibility.

## Configuration
- `PWM_LED_WRAP_EN`
  - **Defined:** duty wraps, matching the legacy bar behaviour. Increment at P gives 0, and decrement at 0 gives P. `cooldown` is loaded as for any action.
  - **Undefined (default):** duty saturates as described in Operation.
  - `sel_idx` wraps in both builds.

## Test plan
Unless stated otherwise, the bench uses LED_COUNT=3, PWM_BITS=2 (P=3) and COOLDOWN=3.
- **Reset.** Hold `rst` 2 cycles with all buttons low. Expect `led`=000, `sel_idx`=0, and all duty 0, with no action taken during reset.
- **Duty ramp.** Press `up` 3 times, each press spaced ≥8 cycles apart. Expect `led[0]` high 1/3, then 2/3, then 3/3 of cycles. `led[2:1]` stays 0.
- **Saturation and wrap.**
  - Press `up` a 4th time. Duty stays 3.
  - Rebuild with `PWM_LED_WRAP_EN`. The same press gives duty 0 and `led[0]` constantly 0.
- **Channel select.**
  - Press `sel` then `up`. Expect `sel_idx`=1 and `duty[1]`=1, with `duty[0]` unchanged.
  - Press `sel` 2 more times. `sel_idx` wraps to 0.
- **Cooldown and conflicts.**
  - Hold `up` for 20 cycles. Expect exactly 3 increments, at cycles 0, 8 and 16.
  - Hold `up` and `down` together. Expect no change and `cooldown` stays 0.
- **Reset mid-cooldown.** Assert `rst` 3 cycles after a press, then press `up` on the first cycle after reset release. Expect it accepted immediately, giving `duty[0]`=1.
